// File: rtl/parking_gate_counter.sv
// Parking gate counter: synchronised/debounced entry and exit beams, saturating occupancy count, timed barrier FSM.
// Optional sticky underflow flag exit_err is built only when PARKING_EXIT_ERR_EN is defined.
module parking_gate_counter #(
    parameter int CAPACITY         = 8,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int GATE_OPEN_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    output logic [3:0] car_count,
    output logic       full,
    output logic       empty,
    output logic       gate_open,
    output logic       entry_reject,
    output logic       exit_err
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

    typedef enum logic {IDLE, OPEN} gate_state_e;

    // Bit 0 = entry beam, bit 1 = exit beam
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]         stb;

    logic [3:0]         count_q, count_d;
    logic               full_q, full_d, empty_q, empty_d;
    logic               reject_q, reject_d;
    logic               entry_acc;
    gate_state_e        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               gate_q, gate_d;

    always_comb begin
        sync1_d    = {exit_sensor, entry_sensor};
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        dcnt_d     = '0;
        // Any agreeing cycle leaves the run counter at zero
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = ~deb_q[i];
                else                                       dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    assign stb = deb_q & ~deb_prev_q;

    always_comb begin
        count_d   = count_q;
        reject_d  = 1'b0;
        entry_acc = 1'b0;
        case (stb)
            2'b11: entry_acc = 1'b1;
            2'b01: begin
                if (count_q == 4'(CAPACITY)) reject_d = 1'b1;
                else begin
                    count_d   = count_q + 4'd1;
                    entry_acc = 1'b1;
                end
            end
            2'b10: if (count_q != 4'd0) count_d = count_q - 4'd1;
            default: ;
        endcase
        full_d  = (count_d == 4'(CAPACITY));
        empty_d = (count_d == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: if (entry_acc) begin
                state_d = OPEN;
                timer_d = TW'(GATE_OPEN_CYCLES - 1);
            end
            OPEN: begin
                if (entry_acc)              timer_d = TW'(GATE_OPEN_CYCLES - 1);
                else if (timer_q == '0)     state_d = IDLE;
                else                        timer_d = timer_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        gate_d = (state_d == OPEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            reject_q   <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            gate_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            dcnt_q     <= dcnt_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            reject_q   <= reject_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            gate_q     <= gate_d;
        end
    end

`ifdef PARKING_EXIT_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (stb == 2'b10 && count_q == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign exit_err = err_q;
`else
    assign exit_err = 1'b0;
`endif

    assign car_count    = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign gate_open    = gate_q;
    assign entry_reject = reject_q;

endmodule

// File: tb/tb_parking_gate_counter.sv
// Randomized scoreboard bench for parking_gate_counter: driver pushes expected outputs per clock,
// monitor pops and compares after every rising edge.
module tb_parking_gate_counter;

    localparam int D   = 4;
    localparam int G   = 10;
    localparam int CAP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor  = 1'b0;
    logic [3:0] car_count;
    logic       full, empty, gate_open, entry_reject, exit_err;

    parking_gate_counter #(.CAPACITY(CAP), .DEBOUNCE_CYCLES(D), .GATE_OPEN_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .car_count(car_count), .full(full), .empty(empty), .gate_open(gate_open),
        .entry_reject(entry_reject), .exit_err(exit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       gate;
        logic       rej;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: raw -> 2-cycle delay -> level accepted after D consecutive disagreeing samples
    int m_s1[2], m_s2[2], m_deb[2], m_run[2], m_pend[2];
    int m_cnt, m_err, last_acc, n_edge;
    int rejects_seen, fulls_seen, both_seen;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0; m_pend[i] = 0;
        end
        m_cnt    = 0;
        m_err    = 0;
        last_acc = -1;
    endtask

    task automatic model_step(input logic e, input logic x);
        int   raw[2];
        int   ev[2];
        exp_t ex;
        raw[0] = int'(e);
        raw[1] = int'(x);
        n_edge++;
        for (int i = 0; i < 2; i++) begin
            ev[i]   = m_pend[i];
            m_pend[i] = 0;
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i]  = 1 - m_deb[i];
                    m_run[i]  = 0;
                    m_pend[i] = m_deb[i];
                end
            end else m_run[i] = 0;
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        ex.rej = 1'b0;
        if (ev[0] != 0 && ev[1] != 0) begin
            last_acc = n_edge;
            both_seen++;
        end else if (ev[0] != 0) begin
            if (m_cnt == CAP) ex.rej = 1'b1;
            else begin
                m_cnt++;
                last_acc = n_edge;
            end
        end else if (ev[1] != 0) begin
            if (m_cnt > 0) m_cnt--;
`ifdef PARKING_EXIT_ERR_EN
            else m_err = 1;
`endif
        end
        ex.cnt   = 4'(m_cnt);
        ex.full  = (m_cnt == CAP);
        ex.empty = (m_cnt == 0);
        ex.gate  = (last_acc >= 0) && (n_edge - last_acc < G);
        ex.err   = (m_err != 0);
        if (ex.rej) rejects_seen++;
        if (ex.full) fulls_seen++;
        exp_q.push_back(ex);
    endtask

    task automatic step(input logic e, input logic x);
        @(negedge clk);
        entry_sensor = e;
        exit_sensor  = x;
        model_step(e, x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        #1;
        checks++;
        if (car_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || gate_open !== 1'b0 ||
            entry_reject !== 1'b0 || exit_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d full=%b empty=%b gate=%b rej=%b err=%b, need cnt=0 full=0 empty=1 gate=0 rej=0 err=0",
                     car_count, full, empty, gate_open, entry_reject, exit_err);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_step(1'b0, 1'b0);
    endtask

    // Monitor: one expected record per post-reset rising edge
    initial begin
        exp_t ex;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                act = {car_count, full, empty, gate_open, entry_reject, exit_err};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at %0t: got output %h with no expectation queued", $time, act);
                end else begin
                    ex = exp_q.pop_front();
                    if (act !== ex) begin
                        errors++;
                        $display("FAIL outputs at %0t: got cnt=%0d full=%b empty=%b gate=%b rej=%b err=%b, need cnt=%0d full=%b empty=%b gate=%b rej=%b err=%b",
                                 $time, act.cnt, act.full, act.empty, act.gate, act.rej, act.err,
                                 ex.cnt, ex.full, ex.empty, ex.gate, ex.rej, ex.err);
                    end
                end
            end
        end
    end

    task automatic episode(input int kind);
        int len, len2, off, gap, tot;
        len  = $urandom_range(1, D + 5);
        len2 = $urandom_range(1, D + 5);
        off  = $urandom_range(0, 3);
        gap  = $urandom_range(2, D + 8);
        case (kind)
            0, 1, 2, 3: for (int c = 0; c < len; c++) step(1'b1, 1'b0);
            4, 5:       for (int c = 0; c < len; c++) step(1'b0, 1'b1);
            6:          for (int c = 0; c < D + 2; c++) step(1'b1, 1'b1);
            7: begin
                tot = off + len2;
                if (len > tot) tot = len;
                for (int c = 0; c < tot; c++) step(c < len, (c >= off) && (c < off + len2));
            end
            default:    for (int c = 0; c < $urandom_range(1, D - 1); c++) step(1'b1, 1'b0);
        endcase
        for (int c = 0; c < gap; c++) step(1'b0, 1'b0);
    endtask

    initial begin
        n_edge = 0;
        rejects_seen = 0; fulls_seen = 0; both_seen = 0;
        model_reset();
        do_reset();
        // Underflow from empty, then a glitch that must not count
        for (int c = 0; c < D + 2; c++) step(1'b0, 1'b1);
        for (int c = 0; c < D + 3; c++) step(1'b0, 1'b0);
        for (int c = 0; c < D - 1; c++) step(1'b1, 1'b0);
        for (int c = 0; c < D + 3; c++) step(1'b0, 1'b0);
        // Fill past capacity with clean entries
        for (int k = 0; k < CAP + 2; k++) begin
            for (int c = 0; c < D + 2; c++) step(1'b1, 1'b0);
            for (int c = 0; c < D + 2; c++) step(1'b0, 1'b0);
        end
        episode(6);
        for (int k = 0; k < 120; k++) begin
            episode($urandom_range(0, 8));
            if (k == 60) do_reset();
        end
        // Mid-operation reset right after an accepted entry with the gate open
        for (int c = 0; c < D + 4; c++) step(1'b1, 1'b0);
        do_reset();
        for (int k = 0; k < 60; k++) episode($urandom_range(0, 8));
        for (int c = 0; c < G + 4; c++) step(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, need 0", exp_q.size());
        end
        checks++;
        if (rejects_seen == 0 || fulls_seen == 0 || both_seen == 0) begin
            errors++;
            $display("FAIL stimulus_coverage: got rejects=%0d fulls=%0d both=%0d, need all nonzero",
                     rejects_seen, fulls_seen, both_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
